// File: rtl/debug_access_ctrl.sv
// debug_access_ctrl: sequences host debug commands into one-cycle decode debug-port accesses,
// handling core halt request/timeout and an optional sticky halt between commands.
module debug_access_ctrl #(
   parameter int N            = 64,
   parameter int HALT_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [4:0]    cmd_reg,
   input  logic [11:0]   cmd_csr,
   input  logic [N-1:0]  cmd_mask,
   input  logic          cmd_hold,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_data,
   output logic          rsp_err,
   output logic          halt_req,
   input  logic          halted,
   output logic          weDB_D,
   output logic          csrDB_D,
   output logic [11:0]   csrAddrDB_D,
   output logic [4:0]    readRegDB_D,
   output logic [4:0]    writeRegDB_D,
   output logic [N-1:0]  writeDataDB_D,
   input  logic [N-1:0]  readDataDB_D
);
   typedef enum logic [1:0] {IDLE, HALT_WAIT, ACCESS, RESP} state_t;
   localparam logic [1:0] OP_CSR  = 2'b01;
   localparam logic [1:0] OP_FLIP = 2'b10;
   localparam int CW = ($clog2(HALT_TIMEOUT + 1) > 8) ? $clog2(HALT_TIMEOUT + 1) : 8;
   state_t          state_q;
   logic [1:0]      op_q, op_d;
   logic [4:0]      reg_q, reg_d;
   logic [11:0]     csr_q, csr_d;
   logic [N-1:0]    mask_q, mask_d;
   logic            cmd_hold_q, hold_q;
   logic [CW-1:0]   cnt_q;
   logic            cmd_ready_q, rsp_valid_q, rsp_err_q, halt_req_q;
   logic [N-1:0]    rsp_data_q;
   logic            we_q, csr_sel_q;
   logic [11:0]     csr_addr_q;
   logic [4:0]      rreg_q, wreg_q;
   logic [N-1:0]    wdata_q;
   logic            accept, bad, go_acc, timeout, acc_csr, acc_flip;
   // Debug-port values for the next cycle come from the live command when the
   // held-halted fast path jumps straight from IDLE into ACCESS.
   always_comb begin
      accept   = (state_q == IDLE) && cmd_valid;
      op_d     = accept ? cmd_op : op_q;
      reg_d    = accept ? cmd_reg : reg_q;
      csr_d    = accept ? cmd_csr : csr_q;
      mask_d   = accept ? cmd_mask : mask_q;
      bad      = (cmd_op == 2'b11) || (cmd_op == OP_FLIP && cmd_reg == 5'd0);
      go_acc   = (accept && !bad && hold_q && halted) || (state_q == HALT_WAIT && halted);
      timeout  = (state_q == HALT_WAIT) && !halted && (cnt_q == CW'(HALT_TIMEOUT - 1));
      acc_csr  = go_acc && (op_d == OP_CSR);
      acc_flip = go_acc && (op_d == OP_FLIP);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= '0;
         reg_q       <= '0;
         csr_q       <= '0;
         mask_q      <= '0;
         cmd_hold_q  <= 1'b0;
         hold_q      <= 1'b0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         halt_req_q  <= 1'b0;
         we_q        <= 1'b0;
         csr_sel_q   <= 1'b0;
         csr_addr_q  <= '0;
         rreg_q      <= '0;
         wreg_q      <= '0;
         wdata_q     <= '0;
      end else begin
         we_q       <= acc_flip;
         csr_sel_q  <= acc_csr;
         csr_addr_q <= acc_csr ? csr_d : '0;
         rreg_q     <= (go_acc && !acc_csr) ? reg_d : '0;
         wreg_q     <= acc_flip ? reg_d : '0;
         wdata_q    <= acc_flip ? mask_d : '0;
         case (state_q)
            IDLE: if (cmd_valid) begin
               op_q        <= cmd_op;
               reg_q       <= cmd_reg;
               csr_q       <= cmd_csr;
               mask_q      <= cmd_mask;
               cmd_hold_q  <= cmd_hold;
               cmd_ready_q <= 1'b0;
               cnt_q       <= '0;
               if (bad) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                  hold_q      <= 1'b0;
                  halt_req_q  <= 1'b0;
               end else if (hold_q && halted) begin
                  state_q <= ACCESS;
               end else begin
                  halt_req_q <= 1'b1;
                  state_q    <= HALT_WAIT;
               end
            end
            HALT_WAIT: if (halted) begin
               state_q <= ACCESS;
            end else if (timeout) begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b1;
               rsp_data_q  <= '0;
               halt_req_q  <= 1'b0;
               hold_q      <= 1'b0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            ACCESS: begin
               rsp_data_q  <= readDataDB_D;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               hold_q      <= cmd_hold_q;
               halt_req_q  <= cmd_hold_q;
               state_q     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;
   assign halt_req      = halt_req_q;
   assign weDB_D        = we_q;
   assign csrDB_D       = csr_sel_q;
   assign csrAddrDB_D   = csr_addr_q;
   assign readRegDB_D   = rreg_q;
   assign writeRegDB_D  = wreg_q;
   assign writeDataDB_D = wdata_q;
endmodule

// File: tb/tb_debug_access_ctrl.sv
// tb_debug_access_ctrl: directed bench with a small decode register-file/CSR model.
module tb_debug_access_ctrl;
   localparam int N = 64;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_hold = 1'b0;
   logic [1:0]    cmd_op = '0;
   logic [4:0]    cmd_reg = '0;
   logic [11:0]   cmd_csr = '0;
   logic [N-1:0]  cmd_mask = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [N-1:0]  rsp_data;
   logic          halt_req, halted = 1'b0;
   logic          weDB_D, csrDB_D;
   logic [11:0]   csrAddrDB_D;
   logic [4:0]    readRegDB_D, writeRegDB_D;
   logic [N-1:0]  writeDataDB_D, readDataDB_D;
   logic [N-1:0]  regs [32];
   int            we_tot = 0, db_tot = 0, halt_tot = 0;
   int            vectors = 0, miss = 0;
   int            s_we, s_db, s_halt;

   always #5 clk = ~clk;

   debug_access_ctrl #(.N(N), .HALT_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_csr(cmd_csr), .cmd_mask(cmd_mask),
      .cmd_hold(cmd_hold), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .halt_req(halt_req), .halted(halted),
      .weDB_D(weDB_D), .csrDB_D(csrDB_D), .csrAddrDB_D(csrAddrDB_D),
      .readRegDB_D(readRegDB_D), .writeRegDB_D(writeRegDB_D),
      .writeDataDB_D(writeDataDB_D), .readDataDB_D(readDataDB_D)
   );

   // Decode model: combinational read, XOR write on the debug write enable.
   assign readDataDB_D = csrDB_D ? ((csrAddrDB_D == 12'hF14) ? 64'hDEAD_BEEF_0000_0F14 : '0)
                                 : regs[readRegDB_D];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
         regs[1] <= 64'h1111;
         regs[5] <= 64'h00FF;
         regs[7] <= 64'h0010;
      end else if (weDB_D && writeRegDB_D != 5'd0) begin
         regs[writeRegDB_D] <= regs[writeRegDB_D] ^ writeDataDB_D;
      end
      we_tot   <= we_tot + int'(weDB_D);
      db_tot   <= db_tot + int'(weDB_D || csrDB_D || csrAddrDB_D != 0 || readRegDB_D != 0
                                || writeRegDB_D != 0 || writeDataDB_D != 0);
      halt_tot <= halt_tot + int'(halt_req);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [1:0] op, input logic [4:0] r, input logic [11:0] c,
                         input logic [N-1:0] m, input logic h);
      cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_csr = c; cmd_mask = m; cmd_hold = h;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("accepted", cmd_ready, 1'b0);
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_arrives", rsp_valid, 1'b1);
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("back_idle", cmd_ready, 1'b1);
      chk("rsp_dropped", rsp_valid, 1'b0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_halt_req", halt_req, 1'b0);
      chk("rst_we", weDB_D, 1'b0);
      // READ_REG x5, halted arrives two cycles after halt_req
      s_we = we_tot;
      accept(2'b00, 5'd5, '0, '0, 1'b0);
      chk("rd_halt_req", halt_req, 1'b1);
      @(negedge clk);
      halted = 1'b1;
      wait_rsp();
      chk("rd_data", rsp_data, 64'h00FF);
      chk("rd_err", rsp_err, 1'b0);
      chk("rd_no_we", we_tot - s_we, 0);
      chk("rd_halt_rel", halt_req, 1'b0);
      take_rsp();
      // FLIP_REG x7 ^= 1, then read back
      s_we = we_tot;
      accept(2'b10, 5'd7, '0, 64'h1, 1'b0);
      wait_rsp();
      chk("flip_data", rsp_data, 64'h10);
      chk("flip_err", rsp_err, 1'b0);
      chk("flip_we_once", we_tot - s_we, 1);
      take_rsp();
      accept(2'b00, 5'd7, '0, '0, 1'b0);
      wait_rsp();
      chk("flip_readback", rsp_data, 64'h11);
      take_rsp();
      // READ_CSR with hold, then READ_REG releasing hold via fast path
      accept(2'b01, '0, 12'hF14, '0, 1'b1);
      wait_rsp();
      chk("csr_data", rsp_data, 64'hDEAD_BEEF_0000_0F14);
      chk("csr_held", halt_req, 1'b1);
      take_rsp();
      chk("held_idle", halt_req, 1'b1);
      accept(2'b00, 5'd1, '0, '0, 1'b0);
      chk("fast_access_rreg", readRegDB_D, 5'd1);
      chk("fast_access_csr", csrDB_D, 1'b0);
      @(negedge clk);
      chk("fast_rsp_valid", rsp_valid, 1'b1);
      chk("fast_data", rsp_data, 64'h1111);
      chk("fast_halt_rel", halt_req, 1'b0);
      take_rsp();
      halted = 1'b0;
      // halt timeout after four HALT_WAIT cycles
      s_db = db_tot;
      accept(2'b00, 5'd3, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      chk("to_not_yet", rsp_valid, 1'b0);
      chk("to_halt_req", halt_req, 1'b1);
      @(negedge clk);
      chk("to_rsp_valid", rsp_valid, 1'b1);
      chk("to_err", rsp_err, 1'b1);
      chk("to_data", rsp_data, '0);
      chk("to_halt_rel", halt_req, 1'b0);
      chk("to_no_db", db_tot - s_db, 0);
      take_rsp();
      // FLIP x0 and reserved op: immediate error, response held stable
      s_halt = halt_tot;
      accept(2'b10, 5'd0, '0, 64'hFF, 1'b0);
      chk("x0_rsp_valid", rsp_valid, 1'b1);
      chk("x0_err", rsp_err, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("x0_hold_valid", rsp_valid, 1'b1);
         chk("x0_hold_err", rsp_err, 1'b1);
         chk("x0_hold_data", rsp_data, '0);
      end
      take_rsp();
      accept(2'b11, 5'd4, '0, '0, 1'b0);
      chk("rsvd_rsp_valid", rsp_valid, 1'b1);
      chk("rsvd_err", rsp_err, 1'b1);
      take_rsp();
      chk("err_no_halt", halt_tot - s_halt, 0);
      // reset while waiting for halt
      accept(2'b00, 5'd2, '0, '0, 1'b0);
      chk("pre_rst_halt_req", halt_req, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
      chk("mid_rst_halt_req", halt_req, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_rreg", readRegDB_D, 5'd0);
      chk("mid_rst_we", weDB_D, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end
endmodule
